// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider issue controller.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [31:0] DZ_QUO          = 32'hFFFF_FFFF;
  localparam int          TIMEOUT_CYC_DEF = 40;
  localparam int          DRAIN_CYC_DEF   = 2;

endpackage

// File: rtl/div_issue_ctrl.sv
// Sequences one DIV/DIVU at a time into the iterative divider and returns quo/rem/tag by valid/ready.
// Optional DIV_CTRL_DZ_BYPASS_EN: zero divisor skips the divider and completes the cycle after accept.
module div_issue_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int TAG_W       = 5,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int DRAIN_CYC   = DRAIN_CYC_DEF
) (
  input  logic             div_clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic [31:0]      req_x,
  input  logic [31:0]      req_y,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_quo,
  output logic [31:0]      res_rem,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_dz,
  output logic             res_timeout,
  output logic             busy,
  output logic             div_go,
  output logic             div_signed,
  output logic [31:0]      div_x,
  output logic [31:0]      div_y,
  input  logic [31:0]      div_s,
  input  logic [31:0]      div_r,
  input  logic             div_complete
);

  localparam logic [5:0] TO_LAST    = 6'(TIMEOUT_CYC - 1);
  localparam logic [5:0] DRAIN_LAST = 6'(DRAIN_CYC - 1);

  state_e             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic               go_q, go_d;
  logic               sg_q, sg_d;
  logic [31:0]        x_q, x_d;
  logic [31:0]        y_q, y_d;
  logic [31:0]        quo_q, quo_d;
  logic [31:0]        rem_q, rem_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               dz_q, dz_d;
  logic               to_q, to_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_d    = go_q;
    sg_d    = sg_q;
    x_d     = x_q;
    y_d     = y_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    tag_d   = tag_q;
    dz_d    = dz_q;
    to_d    = to_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          x_d   = req_x;
          y_d   = req_y;
          sg_d  = req_signed;
          tag_d = req_tag;
          dz_d  = (req_y == '0);
          to_d  = 1'b0;
          cnt_d = '0;
`ifdef DIV_CTRL_DZ_BYPASS_EN
          if (req_y == '0) begin
            quo_d   = DZ_QUO;
            rem_d   = req_x;
            state_d = ST_DONE;
          end else begin
            go_d    = 1'b1;
            state_d = ST_RUN;
          end
`else
          go_d    = 1'b1;
          state_d = ST_RUN;
`endif
        end
      end
      ST_RUN: begin
        // flush outranks a completion arriving on the same edge
        if (flush) begin
          go_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else if (div_complete) begin
          quo_d   = div_s;
          rem_d   = div_r;
          go_d    = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == TO_LAST) begin
          quo_d   = '0;
          rem_d   = '0;
          to_d    = 1'b1;
          go_d    = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_DONE: begin
        if (flush || res_ready) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        // div_go stays low here so the divider sees a clean restart
        if (cnt_q == DRAIN_LAST) state_d = ST_IDLE;
        else                     cnt_d   = cnt_q + 6'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      go_q    <= 1'b0;
      sg_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      tag_q   <= '0;
      dz_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      go_q    <= go_d;
      sg_q    <= sg_d;
      x_q     <= x_d;
      y_q     <= y_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      tag_q   <= tag_d;
      dz_q    <= dz_d;
      to_q    <= to_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign res_valid   = (state_q == ST_DONE) && !flush;
  assign res_quo     = quo_q;
  assign res_rem     = rem_q;
  assign res_tag     = tag_q;
  assign res_dz      = dz_q;
  assign res_timeout = to_q;
  assign div_go      = go_q;
  assign div_signed  = sg_q;
  assign div_x       = x_q;
  assign div_y       = y_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl with a shift-subtract divider behind the div_* ports
// and an arithmetic reference model for expected results.
module tb_div_issue_ctrl;

  localparam int TIMEOUT_CYC = 40;

  logic        div_clk;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_signed;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic [4:0]  req_tag;
  logic        flush;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_quo;
  logic [31:0] res_rem;
  logic [4:0]  res_tag;
  logic        res_dz;
  logic        res_timeout;
  logic        busy;
  logic        div_go;
  logic        div_signed;
  logic [31:0] div_x;
  logic [31:0] div_y;
  logic [31:0] div_s;
  logic [31:0] div_r;
  logic        div_complete;

  int n_chk = 0;
  int n_bad = 0;

  div_issue_ctrl #(.TAG_W(5), .TIMEOUT_CYC(TIMEOUT_CYC), .DRAIN_CYC(2)) dut (
    .div_clk(div_clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .req_x(req_x), .req_y(req_y), .req_tag(req_tag), .flush(flush),
    .res_valid(res_valid), .res_ready(res_ready), .res_quo(res_quo), .res_rem(res_rem),
    .res_tag(res_tag), .res_dz(res_dz), .res_timeout(res_timeout), .busy(busy),
    .div_go(div_go), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
    .div_s(div_s), .div_r(div_r), .div_complete(div_complete)
  );

  initial div_clk = 1'b0;
  always #5 div_clk = ~div_clk;

  // ---------------- iterative divider model (radix-2 restoring) ----------------
  bit          div_hang = 0;
  logic        inj_cmpl = 1'b0;
  logic        dv_cmpl;
  logic [5:0]  dv_ph;
  logic [32:0] dv_rem;
  logic [31:0] dv_q, dv_d;
  logic        dv_nq, dv_nr;

  function automatic logic [31:0] mag(input logic neg, input logic [31:0] v);
    return neg ? -v : v;
  endfunction

  function automatic logic [64:0] dv_step(input logic [32:0] r, input logic [31:0] q,
                                          input logic [31:0] d);
    logic [32:0] rs;
    logic [31:0] qs;
    rs = {r[31:0], q[31]};
    qs = {q[30:0], 1'b0};
    if (rs >= {1'b0, d}) begin
      rs    = rs - {1'b0, d};
      qs[0] = 1'b1;
    end
    return {rs, qs};
  endfunction

  always @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      dv_ph   <= '0;
      dv_cmpl <= 1'b0;
      div_s   <= '0;
      div_r   <= '0;
    end else begin
      dv_cmpl <= 1'b0;
      if (!div_go) begin
        dv_ph <= '0;
      end else if (dv_ph == 6'd0) begin
        dv_rem <= '0;
        dv_q   <= mag(div_signed && div_x[31], div_x);
        dv_d   <= mag(div_signed && div_y[31], div_y);
        dv_nq  <= div_signed && (div_x[31] ^ div_y[31]) && (div_y != 0);
        dv_nr  <= div_signed && div_x[31];
        dv_ph  <= 6'd1;
      end else if (dv_ph <= 6'd32) begin
        {dv_rem, dv_q} <= dv_step(dv_rem, dv_q, dv_d);
        dv_ph <= dv_ph + 6'd1;
      end else if (dv_ph == 6'd33) begin
        if (!div_hang) begin
          dv_cmpl <= 1'b1;
          div_s   <= dv_nq ? -dv_q : dv_q;
          div_r   <= dv_nr ? -dv_rem[31:0] : dv_rem[31:0];
        end
        dv_ph <= 6'd34;
      end
    end
  end

  assign div_complete = dv_cmpl | inj_cmpl;

  // ---------------- reference model and checking ----------------
  function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] x, input logic [31:0] y);
    longint a, b, q, r;
    if (y == 0) return {32'hFFFF_FFFF, x};
    a = sg ? longint'($signed(x)) : longint'(x);
    b = sg ? longint'($signed(y)) : longint'(y);
    q = a / b;
    r = a % b;
    return {q[31:0], r[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op at a negedge with req_ready high; return at a negedge after the result handshake.
  task automatic do_op(input bit sg, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] tag, input int hold);
    logic [63:0] e;
    bit          byp;
    bit          to;
    int          lat, ccyc, exp_lat;
    bit          rdy_leak, go_leak;
    e   = ref_div(sg, x, y);
    byp = 0;
`ifdef DIV_CTRL_DZ_BYPASS_EN
    byp = (y == 0);
`endif
    to = div_hang && !byp;
    if (to) e = 64'd0;
    chk("req_rdy_idle", req_ready, 1);
    req_valid = 1; req_signed = sg; req_x = x; req_y = y; req_tag = tag;
    @(negedge div_clk);
    req_valid = 0; req_x = $urandom; req_y = $urandom; req_tag = 5'($urandom);
    chk("busy_acc", busy, 1);
    chk("go_acc", div_go, !byp);
    if (!byp) begin
      chk("div_x", div_x, x);
      chk("div_y", div_y, y);
      chk("div_sg", div_signed, sg);
    end
    lat = 0; ccyc = -1; rdy_leak = 0; go_leak = 0;
    while (!res_valid && lat < 100) begin
      if (req_ready) rdy_leak = 1;
      if (byp && div_go) go_leak = 1;
      if (div_complete && ccyc < 0) ccyc = lat;
      @(negedge div_clk);
      lat++;
    end
    if (!res_valid) begin
      chk("res_vld_wait", res_valid, 1);
      return;
    end
    exp_lat = byp ? 0 : (to ? TIMEOUT_CYC : ccyc + 1);
    chk("latency", lat, exp_lat);
    chk("rdy_run", rdy_leak, 0);
    chk("go_byp", go_leak | (byp && div_go), 0);
    chk("quo", res_quo, e[63:32]);
    chk("rem", res_rem, e[31:0]);
    chk("tag", res_tag, tag);
    chk("dz", res_dz, y == 0);
    chk("tmo", res_timeout, to);
    chk("go_done", div_go, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge div_clk);
      chk("hold_vld", res_valid, 1);
      chk("hold_quo", res_quo, e[63:32]);
      chk("hold_rem", res_rem, e[31:0]);
      chk("hold_tag", res_tag, tag);
      chk("hold_rdy", req_ready, 0);
    end
    res_ready = 1;
    @(negedge div_clk);
    res_ready = 0;
    chk("post_vld", res_valid, 0);
    chk("post_rdy", req_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] rx, ry;
    resetn = 0; req_valid = 0; req_signed = 0; req_x = 0; req_y = 0; req_tag = 0;
    flush = 0; res_ready = 0;
    repeat (3) @(negedge div_clk);
    chk("rst_go", div_go, 0);
    chk("rst_vld", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_quo", res_quo, 0);
    chk("rst_rem", res_rem, 0);
    chk("rst_tag", res_tag, 0);
    chk("rst_dxy", {div_x, div_y}, 0);
    chk("rst_flags", {res_dz, res_timeout, div_signed}, 0);
    resetn = 1;
    @(negedge div_clk);

    do_op(0, 32'd100, 32'd7, 5'd1, 0);
    do_op(1, 32'hFFFF_FFF9, 32'd2, 5'd2, 0);

    // flush mid-RUN, stale completion during DRAIN and in IDLE
    req_valid = 1; req_signed = 0; req_x = 32'd77; req_y = 32'd5; req_tag = 5'd3;
    @(negedge div_clk);
    req_valid = 0;
    repeat (9) @(negedge div_clk);
    flush = 1;
    @(negedge div_clk);
    flush = 0;
    chk("fl_go", div_go, 0);
    chk("fl_vld", res_valid, 0);
    chk("fl_busy1", busy, 1);
    inj_cmpl = 1;
    @(negedge div_clk);
    inj_cmpl = 0;
    chk("fl_busy2", busy, 1);
    chk("fl_vld2", res_valid, 0);
    @(negedge div_clk);
    chk("fl_idle", busy, 0);
    chk("fl_rdy", req_ready, 1);
    inj_cmpl = 1;
    @(negedge div_clk);
    inj_cmpl = 0;
    chk("idle_stale", {busy, res_valid}, 0);
    do_op(0, 32'd20, 32'd4, 5'd4, 0);

    // flush/valid together in IDLE: no accept
    req_valid = 1; flush = 1; req_x = 32'd9; req_y = 32'd3;
    @(negedge div_clk);
    req_valid = 0; flush = 0;
    chk("fl_noacc", busy, 0);

    // backpressure then back-to-back
    do_op(0, 32'd1000, 32'd33, 5'd5, 5);
    do_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0);

    // zero divisor
    do_op(0, 32'd123, 32'd0, 5'd7, 1);
    do_op(1, 32'hFFFF_FF00, 32'd0, 5'd8, 0);

    // flush while result waits in DONE
    req_valid = 1; req_signed = 0; req_x = 32'd9; req_y = 32'd2; req_tag = 5'd9;
    @(negedge div_clk);
    req_valid = 0;
    lat = 0;
    while (!res_valid && lat < 100) begin
      @(negedge div_clk);
      lat++;
    end
    chk("dn_vld", res_valid, 1);
    flush = 1;
    #1;
    chk("dn_flush_vld", res_valid, 0);
    @(negedge div_clk);
    flush = 0;
    chk("dn_idle", busy, 0);
    chk("dn_vld2", res_valid, 0);

    // watchdog
    div_hang = 1;
    do_op(0, 32'd1000, 32'd3, 5'd10, 1);
    div_hang = 0;
    do_op(0, 32'd15, 32'd4, 5'd11, 0);

    // random traffic
    for (int n = 0; n < 25; n++) begin
      rx = $urandom;
      case ($urandom_range(0, 5))
        0: ry = 32'd0;
        1: ry = 32'($urandom_range(1, 20));
        2: begin ry = 32'hFFFF_FFFF; rx = 32'h8000_0000; end
        3: begin ry = $urandom; rx = 32'($urandom_range(0, 300)); end
        default: ry = $urandom;
      endcase
      do_op(1'($urandom), rx, ry, 5'($urandom), $urandom_range(0, 3));
    end

    // async reset mid-RUN
    req_valid = 1; req_signed = 0; req_x = 32'd50; req_y = 32'd6; req_tag = 5'd12;
    @(negedge div_clk);
    req_valid = 0;
    repeat (5) @(negedge div_clk);
    chk("pre_rst_go", div_go, 1);
    #2 resetn = 0;
    #1;
    chk("arst_go", div_go, 0);
    chk("arst_busy", busy, 0);
    chk("arst_vld", res_valid, 0);
    chk("arst_regs", {div_x, res_tag}, 0);
    @(negedge div_clk);
    resetn = 1;
    @(negedge div_clk);
    do_op(0, 32'd49, 32'd7, 5'd13, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
